pc_fetch_unit: RTL and testbench

// - Program-counter register and fetch sequencer for the 32-bit CPU; sits directly upstream of the PC+4 adder.
// - Drives pc to the adder's A input (B tied to 4) and to instruction memory; takes the adder result back as pc_plus4.
// - Selects the next PC from sequential, branch, jump or pending redirect.
// - Runs a req/ready handshake with instruction memory and holds the PC under stall.

---
 rtl/pc_fetch_unit.sv | 171 +++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program-counter register and fetch sequencer with req/ready handshake to instruction memory.
// Optional trap redirect to EXC_VECTOR with epc capture is built when PC_EXC_EN is defined.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic [31:0] pc_plus4,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic        fetch_fire,
    output logic        misalign
`ifdef PC_EXC_EN
    ,
    input  logic        exc,
    output logic [31:0] epc
`endif
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        pend_vld_q, pend_vld_d;
    logic        mis_q, mis_d;

    logic        fire;
    logic        redir_live;
    logic [31:0] redir_tgt;
    logic        load_redir;
    logic [31:0] load_tgt;

`ifdef PC_EXC_EN
    logic        exc_live;
    logic        exc_pend_q, exc_pend_d;
    logic [31:0] epc_q, epc_d;
`else
    logic        unused_exc_vector;
    assign unused_exc_vector = ^EXC_VECTOR;
`endif

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= '0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
            mis_q      <= mis_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        fire     = 1'b0;
        unique case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                fire     = imem_ready & ~stall;
                if (imem_ready && stall) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_comb begin
        redir_live = jump | branch_taken;
        redir_tgt  = jump ? jump_target : branch_target;
        pc_d       = pc_q;
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
        mis_d      = mis_q;
        load_redir = 1'b0;
        load_tgt   = '0;

        if (redir_live) begin
            load_redir = 1'b1;
            load_tgt   = redir_tgt;
        end else if (pend_vld_q) begin
            load_redir = 1'b1;
            load_tgt   = pend_tgt_q;
        end
`ifdef PC_EXC_EN
        if (exc_live || exc_pend_q) begin
            load_redir = 1'b1;
            load_tgt   = EXC_VECTOR;
        end
`endif

        // An unconsumed redirect is parked; the newest live one always overwrites it.
        if (fire) begin
            pend_vld_d = 1'b0;
            if (load_redir) begin
                pc_d = {load_tgt[31:2], 2'b00};
                if (load_tgt[1:0] != 2'b00) begin
                    mis_d = 1'b1;
                end
            end else begin
                pc_d = pc_plus4;
            end
        end else if (redir_live) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = redir_tgt;
        end
`ifdef PC_EXC_EN
        if (exc_live) begin
            pend_vld_d = 1'b0;
        end
`endif
    end

`ifdef PC_EXC_EN
    assign exc_live = exc & (state_q != S_BOOT);

    always_comb begin
        exc_pend_d = exc_pend_q;
        epc_d      = epc_q;
        if (fire) begin
            exc_pend_d = 1'b0;
        end else if (exc_live) begin
            exc_pend_d = 1'b1;
        end
        if (exc_live) begin
            epc_d = pc_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            exc_pend_q <= 1'b0;
            epc_q      <= '0;
        end else begin
            exc_pend_q <= exc_pend_d;
            epc_q      <= epc_d;
        end
    end

    assign epc = epc_q;
`endif

    assign pc         = pc_q;
    assign fetch_fire = fire;
    assign misalign   = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit (default build) against a cycle-level behavioural model.
module tb_pc_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic [31:0] pc_plus4;
    logic        imem_ready = 1'b0;
    logic [31:0] pc;
    logic        imem_req;
    logic        fetch_fire;
    logic        misalign;

    int unsigned total  = 0;
    int unsigned passed = 0;

    always #5 CLK = ~CLK;

    // The external PC+4 adder
    assign pc_plus4 = pc + 32'd4;

    pc_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .EXC_VECTOR(32'h0000_0080)
    ) dut (
        .CLK          (CLK),
        .RST_n        (RST_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .pc_plus4     (pc_plus4),
        .imem_ready   (imem_ready),
        .pc           (pc),
        .imem_req     (imem_req),
        .fetch_fire   (fetch_fire),
        .misalign     (misalign)
    );

    // Reference model: booting / held flags, pc, parked redirect, sticky misalign.
    logic [31:0] m_pc;
    logic [31:0] m_pt;
    bit          m_boot, m_hold, m_pv, m_mis;

    function automatic bit m_req();
        return !m_boot && !m_hold;
    endfunction

    function automatic bit m_fire();
        return m_req() && imem_ready && !stall;
    endfunction

    task automatic model_reset();
        m_pc   = 32'h0;
        m_pt   = 32'h0;
        m_boot = 1'b1;
        m_hold = 1'b0;
        m_pv   = 1'b0;
        m_mis  = 1'b0;
    endtask

    task automatic clear_inputs();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        jump          = 1'b0;
        branch_target = '0;
        jump_target   = '0;
        imem_ready    = 1'b0;
    endtask

    task automatic tick();
        bit          f, has;
        logic [31:0] tgt;
        f   = m_fire();
        has = jump || branch_taken;
        tgt = jump ? jump_target : branch_target;
        @(posedge CLK);
        if (f) begin
            if (has) begin
                m_pc  = tgt & 32'hFFFF_FFFC;
                m_mis = m_mis || (tgt[1:0] != 2'b00);
            end else if (m_pv) begin
                m_pc  = m_pt & 32'hFFFF_FFFC;
                m_mis = m_mis || (m_pt[1:0] != 2'b00);
            end else begin
                m_pc = m_pc + 32'd4;
            end
            m_pv = 1'b0;
        end else if (has) begin
            m_pv = 1'b1;
            m_pt = tgt;
        end
        if (m_boot)      m_boot = 1'b0;
        else if (m_hold) m_hold = stall;
        else             m_hold = imem_ready && stall;
        #1;
    endtask

    task automatic apply_reset();
        RST_n = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge CLK);
        RST_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        total++; if (pc !== 32'h0) $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); else passed++;
        total++; if (imem_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", imem_req); else passed++;
        total++; if (fetch_fire !== 1'b0) $display("FAIL reset_fire got=%b exp=0", fetch_fire); else passed++;
        total++; if (misalign !== 1'b0) $display("FAIL reset_misalign got=%b exp=0", misalign); else passed++;
        @(negedge CLK);
        RST_n = 1'b1;
        #1;
    endtask

    task automatic test_sequential();
        imem_ready = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) $display("FAIL boot_req got=%b exp=0", imem_req); else passed++;
        total++; if (fetch_fire !== 1'b0) $display("FAIL boot_fire got=%b exp=0", fetch_fire); else passed++;
        tick();
        for (int i = 0; i < 4; i++) begin
            total++; if (pc !== 32'(i * 4)) $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc, 32'(i * 4)); else passed++;
            total++; if (imem_req !== 1'b1 || fetch_fire !== 1'b1)
                $display("FAIL seq_fire[%0d] got req=%b fire=%b exp=1/1", i, imem_req, fetch_fire);
            else passed++;
            tick();
        end
    endtask

    task automatic test_ready_gap();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (pc !== 32'h10 || fetch_fire !== 1'b0)
                $display("FAIL gap_hold[%0d] got pc=%h fire=%b exp=00000010/0", i, pc, fetch_fire);
            else passed++;
            tick();
        end
        imem_ready = 1'b1;
        #1;
        total++; if (fetch_fire !== 1'b1) $display("FAIL gap_fire got=%b exp=1", fetch_fire); else passed++;
        tick();
        total++; if (pc !== 32'h14) $display("FAIL gap_pc got=%h exp=%h", pc, 32'h14); else passed++;
    endtask

    task automatic test_pending_branch();
        imem_ready    = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        tick();
        branch_taken  = 1'b0;
        branch_target = 32'h1234;
        tick();
        imem_ready = 1'b1;
        #1;
        total++; if (pc !== 32'h14) $display("FAIL pend_wait_pc got=%h exp=%h", pc, 32'h14); else passed++;
        tick();
        total++; if (pc !== 32'h40) $display("FAIL pend_pc got=%h exp=%h", pc, 32'h40); else passed++;
        tick();
        total++; if (pc !== 32'h44) $display("FAIL pend_cleared got=%h exp=%h", pc, 32'h44); else passed++;
    endtask

    task automatic test_jump_priority();
        imem_ready    = 1'b1;
        jump          = 1'b1;
        jump_target   = 32'h100;
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        tick();
        jump = 1'b0;
        branch_taken = 1'b0;
        total++; if (pc !== 32'h100) $display("FAIL jump_prio got=%h exp=%h", pc, 32'h100); else passed++;
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        tick();
        jump = 1'b0;
        total++; if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_top got=%h exp=%h", pc, 32'hFFFF_FFFC); else passed++;
        tick();
        total++; if (pc !== 32'h0) $display("FAIL wrap_zero got=%h exp=%h", pc, 32'h0); else passed++;
        total++; if (misalign !== 1'b0) $display("FAIL aligned_no_mis got=%b exp=0", misalign); else passed++;
    endtask

    task automatic test_misalign();
        imem_ready  = 1'b1;
        jump        = 1'b1;
        jump_target = 32'h42;
        tick();
        jump = 1'b0;
        total++; if (pc !== 32'h40) $display("FAIL mis_pc got=%h exp=%h", pc, 32'h40); else passed++;
        total++; if (misalign !== 1'b1) $display("FAIL mis_set got=%b exp=1", misalign); else passed++;
        for (int i = 0; i < 3; i++) tick();
        total++; if (misalign !== 1'b1) $display("FAIL mis_sticky got=%b exp=1", misalign); else passed++;
        apply_reset();
        total++; if (misalign !== 1'b0) $display("FAIL mis_reset got=%b exp=0", misalign); else passed++;
    endtask

    task automatic test_stall_hold();
        apply_reset();
        imem_ready = 1'b1;
        tick();
        tick();
        tick();
        total++; if (pc !== 32'h8) $display("FAIL stall_start_pc got=%h exp=%h", pc, 32'h8); else passed++;
        stall = 1'b1;
        #1;
        total++; if (fetch_fire !== 1'b0) $display("FAIL stall_fire got=%b exp=0", fetch_fire); else passed++;
        tick();
        total++; if (imem_req !== 1'b0 || pc !== 32'h8)
            $display("FAIL hold_state got req=%b pc=%h exp=0/00000008", imem_req, pc);
        else passed++;
        tick();
        stall = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) $display("FAIL hold_exit_req got=%b exp=0", imem_req); else passed++;
        tick();
        total++; if (imem_req !== 1'b1 || pc !== 32'h8 || fetch_fire !== 1'b1)
            $display("FAIL rerequest got req=%b pc=%h fire=%b exp=1/00000008/1", imem_req, pc, fetch_fire);
        else passed++;
        tick();
        total++; if (pc !== 32'hC) $display("FAIL after_hold_pc got=%h exp=%h", pc, 32'hC); else passed++;
    endtask

    task automatic test_async_reset();
        imem_ready = 1'b1;
        tick();
        tick();
        #2;
        RST_n = 1'b0;
        #1;
        total++; if (pc !== 32'h0 || fetch_fire !== 1'b0 || imem_req !== 1'b0)
            $display("FAIL async_reset got pc=%h fire=%b req=%b exp=00000000/0/0", pc, fetch_fire, imem_req);
        else passed++;
        clear_inputs();
        model_reset();
        @(negedge CLK);
        RST_n = 1'b1;
        #1;
    endtask

    task automatic test_random();
        int unsigned errs;
        logic [31:0] t;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            imem_ready   = ($urandom_range(0, 3) != 0);
            stall        = ($urandom_range(0, 4) == 0);
            jump         = ($urandom_range(0, 9) == 0);
            branch_taken = ($urandom_range(0, 6) == 0);
            t = $urandom;
            if ($urandom_range(0, 15) != 0) t[1:0] = 2'b00;
            jump_target = t;
            t = $urandom;
            if ($urandom_range(0, 15) != 0) t[1:0] = 2'b00;
            branch_target = t;
            #1;
            total++;
            if (pc !== m_pc || imem_req !== m_req() || fetch_fire !== m_fire() || misalign !== m_mis) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL rand[%0d] got pc=%h req=%b fire=%b mis=%b exp pc=%h req=%b fire=%b mis=%b",
                             i, pc, imem_req, fetch_fire, misalign, m_pc, m_req(), m_fire(), m_mis);
            end else passed++;
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ready_gap();
        test_pending_branch();
        test_jump_priority();
        test_misalign();
        test_stall_hold();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
